div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider for the DIV/DIVU path.
- Sits beside the execute stage and is driven by its div_opdata1/div_opdata2/div_start/signed_div outputs.
- Returns a 64-bit {remainder, quotient} result and a ready flag; the execute stage holds its stall request until ready is seen.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; all state clears while rst=0
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  DivStart/DivStop request, held high by execute while it stalls
- annul_i  in  1  pipeline flush (exception/ERET); aborts an operation in progress
- result_o  out  2*DATA_W  [63:32] remainder (to HI), [31:0] quotient (to LO)
- ready_o  out  1  DivResultReady/DivResultNotReady

Behaviour:
- Reset: state=DivFree, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0.
- Operands are sampled only at the DivFree->DivOn or DivFree->DivByZero edge. Later changes on the opdata inputs are ignored.
- FSM states: DivFree, DivByZero, DivOn, DivEnd (2-bit encoding).
- DivFree:
  - start_i=1, annul_i=0, divisor!=0 -> DivOn.
    - Latch |dividend| and |divisor|; absolute values are taken only when signed_div_i=1 and the operand's bit31=1.
    - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
    - cnt=0.
  - start_i=1, annul_i=0, divisor==0 -> DivByZero.
  - Otherwise stay in DivFree; ready_o=0, result_o=0.
- DivByZero: next edge -> DivEnd with result_o=0 and ready_o=1.
- DivOn:
  - annul_i=1 -> DivFree on the next edge; ready_o=0, result_o=0.
  - Otherwise, each edge performs one iteration on a 65-bit working register {partial_rem[32:0], dividend[31:0]}:
    - Shift left 1.
    - Compute trial = partial_rem - {1'b0, divisor}.
    - If trial is non-negative, partial_rem=trial and shift in 1; else shift in 0.
    - cnt++.
  - The edge on which cnt reaches DATA_W (the 32nd iteration) goes to DivEnd. On that edge:
    - Apply sign correction (two's-complement negate of quotient and/or remainder per the latched signs).
    - Register result_o.
    - Set ready_o=1.
- Latency: start sampled at edge E0; ready_o and result_o valid after edge E32 (33 edges); divide-by-zero valid after E1.
- DivEnd:
  - Hold result_o and ready_o=1 while start_i=1.
  - start_i=0 -> DivFree on the next edge; ready_o=0, result_o=0.
  - annul_i in DivEnd is ignored; the result was already consumed or is discarded by execute.
- start_i deasserting during DivOn does not abort; only annul_i aborts.
- Simultaneous start_i=1 and annul_i=1 in DivFree: no start.
- Reset asserted mid-operation returns to the reset state immediately (asynchronous).
- Signed overflow 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. This is the natural result of the absolute-value algorithm; no special case.
- No combinational path from inputs to outputs; both outputs are registers.

Decomposition:
- Shared defines file gets:
  - the FSM state constants DivFree, DivByZero, DivOn, DivEnd;
  - the existing DivStart/DivStop and DivResultReady/DivResultNotReady constants;
  - DoubleRegBus/RegBus widths.
- Single module; no sub-module needed. The 33-bit trial subtractor stays inline.

Test Plan:
- Unsigned 100 / 7, start held -> ready_o rises after 33 edges; result_o=64'h00000002_0000000E; start dropped -> ready_o=0 next cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7 / -2 -> 64'h00000001_FFFFFFFD.
- Divide by zero (0x12345678 / 0) -> ready_o=1 after 2 edges, result_o=0; held while start_i=1.
- annul_i pulsed at iteration 10 of 0xFFFFFFFF / 3 unsigned -> DivFree next edge, ready_o never asserts. A fresh start then yields 64'h00000000_55555555.
- Signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
- rst driven low at iteration 20 -> outputs 0 immediately; after release with start_i=1, operation restarts from operand sampling.

Source files
------------

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the DIV/DIVU divider and the execute stage that
// drives it.
// Contents:
//   RegBus / DoubleRegBus      - single and double register widths
//   div_state_e                - divider FSM states (2-bit encoding)
//   DivStart / DivStop         - levels of the start request from execute
//   DivResultReady / NotReady  - levels of the divider ready flag
// ---------------------------------------------------------------------------
package div_unit_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU
// (unsigned). The divider produces one quotient bit per clock. Operands are
// captured once, when a request leaves DivFree. The result is returned as
// {remainder, quotient} together with a ready flag. Both outputs are
// registers.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned divide
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request level; execute holds it high while it stalls
//   annul_i       pipeline flush; aborts a division that is in progress
//   result_o      [2*DATA_W-1:DATA_W] remainder, [DATA_W-1:0] quotient
//   ready_o       result valid; held until start_i drops
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Working register: {partial remainder [2*DATA_W:DATA_W], dividend/quotient [DATA_W-1:0]}
    logic [2*DATA_W:0]     work_q, work_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    // Operand conditioning. Absolute values are taken only for signed
    // divides of negative operands.
    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     op1_abs, op2_abs;

    // One restoring iteration. The shifted remainder is one bit wider than
    // the stored remainder so that the sign of the trial subtraction is an
    // explicit bit.
    logic [DATA_W+1:0]     shifted_rem;
    logic [DATA_W+1:0]     trial;
    logic [2*DATA_W:0]     step_work;
    logic [DATA_W-1:0]     quot_raw, rem_raw;
    logic [DATA_W-1:0]     quot_fix, rem_fix;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

        shifted_rem = work_q[2*DATA_W:DATA_W-1];
        trial       = shifted_rem - {2'b00, divisor_q};
        if (!trial[DATA_W+1]) begin
            step_work = {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
        end else begin
            step_work = {shifted_rem[DATA_W:0], work_q[DATA_W-2:0], 1'b0};
        end

        quot_raw = step_work[DATA_W-1:0];
        rem_raw  = step_work[2*DATA_W-1:DATA_W];
        quot_fix = quot_neg_q ? (~quot_raw + 1'b1) : quot_raw;
        rem_fix  = rem_neg_q  ? (~rem_raw + 1'b1)  : rem_raw;
    end

    // Next-state and datapath control. Outputs are computed here and
    // registered, so nothing combinational reaches result_o or ready_o.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                // A flush arriving with the request means the instruction is
                // being squashed, so it must not start.
                if (start_i == DivStart && !annul_i) begin
                    work_d     = {{(DATA_W+1){1'b0}}, op1_abs};
                    divisor_d  = op2_abs;
                    quot_neg_d = op1_neg ^ op2_neg;
                    rem_neg_d  = op1_neg;
                    cnt_d      = '0;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                    end
                end
            end

            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // The last iteration writes the sign-corrected result
                    // directly, so ready rises on the same edge.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DivResultReady;
                    end
                end
            end

            DivEnd: begin
                // A flush here is ignored: execute either already took the
                // result or will discard it.
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d = DivFree;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed testbench for div_unit. Each scenario task drives its stimulus
// and compares outputs against hand-computed values, sampling on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int tests_run;
    int tests_failed;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request. The caller is positioned at a falling edge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Count rising edges until ready_o is seen, bounded by limit.
    task automatic wait_ready(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready_o) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic;
        int edges;
        start_op(1'b0, 32'd100, 32'd7);
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 33 || ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL udiv_latency: edges=%0d ready=%b, required edges=33 ready=1", edges, ready_o);
        end
        tests_run++;
        if (result_o !== 64'h00000002_0000000E) begin
            tests_failed++;
            $display("[TB] FAIL udiv_100_7: got %h, required 000000020000000e", result_o);
        end
        // Result holds while start stays high.
        @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            tests_failed++;
            $display("[TB] FAIL udiv_hold: ready=%b result=%h, required ready=1 result=000000020000000e", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL udiv_release: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
    endtask

    task automatic test_signed;
        int edges;
        logic [31:0] a_vec [2];
        logic [31:0] b_vec [2];
        logic [63:0] exp_vec [2];
        a_vec[0] = 32'hFFFFFFF9; b_vec[0] = 32'h00000002; exp_vec[0] = 64'hFFFFFFFF_FFFFFFFD;
        a_vec[1] = 32'h00000007; b_vec[1] = 32'hFFFFFFFE; exp_vec[1] = 64'h00000001_FFFFFFFD;
        for (int i = 0; i < 2; i++) begin
            start_op(1'b1, a_vec[i], b_vec[i]);
            wait_ready(40, edges);
            tests_run++;
            if (edges !== 33 || result_o !== exp_vec[i]) begin
                tests_failed++;
                $display("[TB] FAIL sdiv_%0d: edges=%0d result=%h, required edges=33 result=%h", i, edges, result_o, exp_vec[i]);
            end
            start_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero;
        int edges;
        start_op(1'b0, 32'h12345678, 32'h0);
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 2 || ready_o !== 1'b1 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL div_zero: edges=%0d ready=%b result=%h, required edges=2 ready=1 result=0", edges, ready_o, result_o);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL div_zero_hold: ready=%b, required 1", ready_o);
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_annul;
        int edges;
        logic seen_ready;
        start_op(1'b0, 32'hFFFFFFFF, 32'd3);
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL annul_abort: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) seen_ready = 1'b1;
        end
        tests_run++;
        if (seen_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL annul_no_ready: ready seen=%b, required 0", seen_ready);
        end
        start_op(1'b0, 32'hFFFFFFFF, 32'd3);
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 33 || result_o !== 64'h00000000_55555555) begin
            tests_failed++;
            $display("[TB] FAIL annul_restart: edges=%0d result=%h, required edges=33 result=0000000055555555", edges, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_with_annul;
        int edges;
        start_op(1'b0, 32'd1000, 32'd10);
        annul_i = 1'b1;
        repeat (3) @(negedge clk);
        annul_i = 1'b0;
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 33 || result_o !== 64'h00000000_00000064) begin
            tests_failed++;
            $display("[TB] FAIL start_annul: edges=%0d result=%h, required edges=33 result=0000000000000064", edges, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_boundaries;
        int edges;
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 33 || result_o !== 64'h00000000_80000000) begin
            tests_failed++;
            $display("[TB] FAIL sdiv_overflow: edges=%0d result=%h, required edges=33 result=0000000080000000", edges, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        // Start is a single-cycle pulse and the operands change afterwards:
        // neither may disturb the division.
        start_op(1'b0, 32'hFFFFFFFF, 32'd1);
        @(negedge clk);
        start_i   = 1'b0;
        opdata1_i = 32'h00000005;
        opdata2_i = 32'h00000003;
        edges = 0;
        while (edges < 40 && !ready_o) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        tests_run++;
        if (edges !== 32 || result_o !== 64'h00000000_FFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL udiv_max_by_1: edges after E0=%0d result=%h, required 32 result=00000000ffffffff", edges, result_o);
        end
        @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pulse_release: ready=%b, required 0", ready_o);
        end
    endtask

    task automatic test_reset_mid;
        int edges;
        start_op(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_ready(40, edges);
        tests_run++;
        if (edges !== 33 || result_o !== 64'hFFFFFFFE_FFFFFFF2) begin
            tests_failed++;
            $display("[TB] FAIL reset_restart: edges=%0d result=%h, required edges=33 result=fffffffefffffff2", edges, result_o);
        end
        // Reset while the result is held must clear it without a clock edge.
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_end: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_by_zero();
        test_annul();
        test_start_with_annul();
        test_boundaries();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_div_unit
